// File: rtl/team_04_pkg.sv
// Shared types and constants for the team_04 Wishbone master bridge.
package team_04_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    RESP = 2'b10
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // True when the request must be answered with an error instead of a bus cycle.
  function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] adr_lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return adr_lo[0];
      SZ_WORD: return adr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/team_04_lane_align.sv
// Byte-lane steering: store data/enables onto the bus, load data back to bit 0.
module team_04_lane_align
  import team_04_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  adr_lo_i,
  input  logic [31:0] wdat_i,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dat_o,
  output logic [31:0] rdat_o
);

  logic [31:0] rd_shift;

  assign rd_shift = dat_i >> {adr_lo_i, 3'b000};

  always_comb begin
    sel_o  = 4'b0000;
    dat_o  = 32'h0;
    rdat_o = 32'h0;
    case (size_i)
      SZ_BYTE: begin
        sel_o  = 4'b0001 << adr_lo_i;
        dat_o  = {24'h0, wdat_i[7:0]} << {adr_lo_i, 3'b000};
        rdat_o = {24'h0, rd_shift[7:0]};
      end
      SZ_HALF: begin
        sel_o  = 4'b0011 << adr_lo_i;
        dat_o  = {16'h0, wdat_i[15:0]} << {adr_lo_i[1], 4'b0000};
        rdat_o = {16'h0, rd_shift[15:0]};
      end
      SZ_WORD: begin
        sel_o  = 4'b1111;
        dat_o  = wdat_i;
        rdat_o = rd_shift;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/team_04_wb_master_if.sv
// CPU load/store port to Wishbone B4 classic master: one request at a time,
// single bus cycle with ACK timeout, right-aligned zero-extended response.
module team_04_wb_master_if
  import team_04_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_adr_i,
  input  logic [31:0] req_wdat_i,
  input  logic [1:0]  req_size_i,
  output logic        rsp_valid_o,
  output logic [31:0] rsp_rdat_o,
  output logic        rsp_err_o,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  output logic [3:0]  SEL_O,
  output logic        WE_O,
  output logic        STB_O,
  output logic        CYC_O,
  input  logic [31:0] DAT_I,
  input  logic        ACK_I
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdat_q, wdat_d;
  logic [1:0]  size_q, size_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdat_q, rdat_d;

  logic [3:0]  lane_sel;
  logic [31:0] lane_dat;
  logic [31:0] lane_rdat;
  logic        bus_active;
  logic        resp_active;

  team_04_lane_align u_lane_align (
    .size_i   (size_q),
    .adr_lo_i (adr_q[1:0]),
    .wdat_i   (wdat_q),
    .dat_i    (DAT_I),
    .sel_o    (lane_sel),
    .dat_o    (lane_dat),
    .rdat_o   (lane_rdat)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdat_d  = rdat_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          we_d   = req_we_i;
          adr_d  = req_adr_i;
          wdat_d = req_wdat_i;
          size_d = req_size_i;
          cnt_d  = 8'h0;
          rdat_d = 32'h0;
          err_d  = req_illegal(req_size_i, req_adr_i[1:0]);
          state_d = err_d ? RESP : BUS;
        end
      end
      BUS: begin
        // ACK_I takes priority over a timeout firing in the same cycle.
        if (ACK_I) begin
          rdat_d  = we_q ? 32'h0 : lane_rdat;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdat_d  = 32'h0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'h1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= 32'h0;
      wdat_q  <= 32'h0;
      size_q  <= SZ_BYTE;
      cnt_q   <= 8'h0;
      err_q   <= 1'b0;
      rdat_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdat_q  <= rdat_d;
    end
  end

  assign bus_active  = (state_q == BUS);
  assign resp_active = (state_q == RESP);

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = resp_active;
  assign rsp_err_o   = resp_active & err_q;
  assign rsp_rdat_o  = resp_active ? rdat_q : 32'h0;

  // Bus outputs are forced to zero outside the bus cycle.
  assign CYC_O = bus_active;
  assign STB_O = bus_active;
  assign WE_O  = bus_active & we_q;
  assign ADR_O = bus_active ? {adr_q[31:2], 2'b00} : 32'h0;
  assign SEL_O = bus_active ? lane_sel : 4'b0000;
  assign DAT_O = bus_active ? lane_dat : 32'h0;

endmodule

// File: tb/tb_team_04_wb_master_if.sv
// Directed table-driven bench for team_04_wb_master_if (TIMEOUT_CYCLES = 4),
// plus hand-written back-to-back and mid-cycle reset sequences.
module tb_team_04_wb_master_if;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = 32'h0;
  logic [31:0] req_wdat = 32'h0;
  logic [1:0]  req_size = 2'b00;
  logic        rsp_valid;
  logic [31:0] rsp_rdat;
  logic        rsp_err;
  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;
  logic        we_o;
  logic        stb_o;
  logic        cyc_o;
  logic [31:0] dat_i = 32'h0;
  logic        ack_i = 1'b0;

  int err_count = 0;
  int check_count = 0;

  always #5 clk = ~clk;

  team_04_wb_master_if #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_adr_i   (req_adr),
    .req_wdat_i  (req_wdat),
    .req_size_i  (req_size),
    .rsp_valid_o (rsp_valid),
    .rsp_rdat_o  (rsp_rdat),
    .rsp_err_o   (rsp_err),
    .ADR_O       (adr_o),
    .DAT_O       (dat_o),
    .SEL_O       (sel_o),
    .WE_O        (we_o),
    .STB_O       (stb_o),
    .CYC_O       (cyc_o),
    .DAT_I       (dat_i),
    .ACK_I       (ack_i)
  );

  // ack_wait: index of the bus cycle (0 = first) that carries ACK_I, -1 = never.
  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic [1:0]  size;
    int          ack_wait;
    logic [31:0] bus_rdat;
    logic [31:0] exp_adr;
    logic [3:0]  exp_sel;
    logic [31:0] exp_dat;
    logic        exp_we;
    int          exp_cyc;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_rdat;
  } vector_t;

  vector_t vecs[12];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    check_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after an edge with the DUT idle; returns in the same phase.
  task automatic applyStimulus(input int idx);
    vector_t v;
    int bus_idx;
    int lat;
    logic got;
    logic [31:0] seen_adr, seen_dat;
    logic [3:0] seen_sel;
    logic seen_we, seen_err;
    logic [31:0] seen_rdat;
    v = vecs[idx];
    bus_idx = 0; lat = 0; got = 1'b0;
    seen_adr = 32'h0; seen_dat = 32'h0; seen_sel = 4'h0; seen_we = 1'b0;
    seen_err = 1'b0; seen_rdat = 32'h0;
    checkOutput($sformatf("v%0d ready", idx), 32'(req_ready), 32'h1);
    req_valid = 1'b1; req_we = v.we; req_adr = v.adr; req_wdat = v.wdat; req_size = v.size;
    dat_i = v.bus_rdat;
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (rsp_valid) begin
        got = 1'b1; lat = k; seen_err = rsp_err; seen_rdat = rsp_rdat;
        break;
      end
      if (cyc_o) begin
        if (bus_idx == 0) begin
          seen_adr = adr_o; seen_sel = sel_o; seen_dat = dat_o; seen_we = we_o;
        end
        ack_i = (bus_idx == v.ack_wait);
        bus_idx++;
      end
      tick();
      ack_i = 1'b0;
    end
    checkOutput($sformatf("v%0d rsp_seen", idx), 32'(got), 32'h1);
    checkOutput($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    checkOutput($sformatf("v%0d cyc_cycles", idx), 32'(bus_idx), 32'(v.exp_cyc));
    checkOutput($sformatf("v%0d err", idx), 32'(seen_err), 32'(v.exp_err));
    checkOutput($sformatf("v%0d rdat", idx), seen_rdat, v.exp_rdat);
    checkOutput($sformatf("v%0d adr_o", idx), seen_adr, v.exp_adr);
    checkOutput($sformatf("v%0d sel_o", idx), 32'(seen_sel), 32'(v.exp_sel));
    checkOutput($sformatf("v%0d dat_o", idx), seen_dat, v.exp_dat);
    checkOutput($sformatf("v%0d we_o", idx), 32'(seen_we), 32'(v.exp_we));
    tick();
    checkOutput($sformatf("v%0d rsp_one_cycle", idx), 32'(rsp_valid), 32'h0);
  endtask

  initial begin
    int first_acc, second_acc, cyc_low, rsp_cnt, cyc_cnt;
    logic [31:0] last_rdat;
    logic issued_load;

    //         we    adr           wdat          size   ack  bus_rdat      exp_adr       sel      exp_dat       we cyc lat err exp_rdat
    vecs[0]  = '{1'b1, 32'h3000_0003, 32'hFFFF_FFAB, 2'b00, 0,  32'h0,        32'h3000_0000, 4'b1000, 32'hAB00_0000, 1'b1, 1, 2, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h3000_0002, 32'h0,        2'b01, 3,  32'hBEEF_1234, 32'h3000_0000, 4'b1100, 32'h0,        1'b0, 4, 5, 1'b0, 32'h0000_BEEF};
    vecs[2]  = '{1'b0, 32'h3000_0001, 32'h0,        2'b10, -1, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0, 1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 32'h3000_0000, 32'h0,        2'b11, -1, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0, 1, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 32'h3000_0010, 32'h0,        2'b10, -1, 32'hCAFE_F00D, 32'h3000_0010, 4'b1111, 32'h0,        1'b0, 4, 5, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 32'h3000_0020, 32'h0,        2'b10, 3,  32'h1234_5678, 32'h3000_0020, 4'b1111, 32'h0,        1'b0, 4, 5, 1'b0, 32'h1234_5678};
    vecs[6]  = '{1'b0, 32'h3000_0001, 32'h0,        2'b00, 1,  32'hAABB_CCDD, 32'h3000_0000, 4'b0010, 32'h0,        1'b0, 2, 3, 1'b0, 32'h0000_00CC};
    vecs[7]  = '{1'b1, 32'h3000_0000, 32'h1234_5678, 2'b01, 0,  32'h0,        32'h3000_0000, 4'b0011, 32'h0000_5678, 1'b1, 1, 2, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 32'h3000_0003, 32'h0,        2'b01, -1, 32'h0,        32'h0,         4'b0000, 32'h0,        1'b0, 0, 1, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 2'b10, 0,  32'hFFFF_FFFF, 32'h3000_0004, 4'b1111, 32'hDEAD_BEEF, 1'b1, 1, 2, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h3000_0003, 32'h0,        2'b00, 2,  32'h1122_3344, 32'h3000_0000, 4'b1000, 32'h0,        1'b0, 3, 4, 1'b0, 32'h0000_0011};
    vecs[11] = '{1'b1, 32'h3000_0002, 32'hFFFF_A5C3, 2'b01, 0,  32'h0,        32'h3000_0000, 4'b1100, 32'hA5C3_0000, 1'b1, 1, 2, 1'b0, 32'h0};

    // Reset state
    rst = 1'b1;
    tick(); tick();
    checkOutput("reset ready", 32'(req_ready), 32'h1);
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset rsp_err", 32'(rsp_err), 32'h0);
    checkOutput("reset rsp_rdat", rsp_rdat, 32'h0);
    checkOutput("reset cyc", 32'(cyc_o), 32'h0);
    checkOutput("reset stb", 32'(stb_o), 32'h0);
    checkOutput("reset we", 32'(we_o), 32'h0);
    checkOutput("reset adr", adr_o, 32'h0);
    checkOutput("reset sel", 32'(sel_o), 32'h0);
    checkOutput("reset dat", dat_o, 32'h0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 12; i++) applyStimulus(i);

    // Back-to-back: word store then word load with req_valid held high.
    first_acc = -1; second_acc = -1; cyc_low = 0; rsp_cnt = 0; last_rdat = 32'h0;
    issued_load = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_adr = 32'h3000_0100; req_wdat = 32'h0BAD_F00D;
    req_size = 2'b10; dat_i = 32'h5A5A_0F0F;
    for (int c = 0; c < 10; c++) begin
      ack_i = cyc_o;
      if (rsp_valid) begin
        rsp_cnt++;
        last_rdat = rsp_rdat;
      end
      if (first_acc >= 0 && second_acc < 0 && !cyc_o) cyc_low++;
      if (req_valid && req_ready) begin
        if (first_acc < 0) first_acc = c;
        else second_acc = c;
      end
      tick();
      ack_i = 1'b0;
      if (first_acc >= 0 && !issued_load) begin
        req_we = 1'b0; req_adr = 32'h3000_0104; issued_load = 1'b1;
      end else if (second_acc >= 0) begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    checkOutput("b2b accept gap", 32'(second_acc - first_acc), 32'h3);
    checkOutput("b2b cyc dropped", 32'(cyc_low > 0), 32'h1);
    checkOutput("b2b rsp count", 32'(rsp_cnt), 32'h2);
    checkOutput("b2b load rdat", last_rdat, 32'h5A5A_0F0F);

    // Reset pulsed mid-bus-cycle, then stray ACK_I.
    tick();
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h3000_0200; req_size = 2'b10;
    tick();
    req_valid = 1'b0;
    checkOutput("rst_mid cyc before", 32'(cyc_o), 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("rst_mid cyc", 32'(cyc_o), 32'h0);
    checkOutput("rst_mid stb", 32'(stb_o), 32'h0);
    checkOutput("rst_mid ready", 32'(req_ready), 32'h1);
    checkOutput("rst_mid rsp_valid", 32'(rsp_valid), 32'h0);
    rsp_cnt = 0; cyc_cnt = 0;
    for (int c = 0; c < 4; c++) begin
      ack_i = 1'b1; dat_i = 32'hFFFF_FFFF;
      tick();
      if (rsp_valid) rsp_cnt++;
      if (cyc_o) cyc_cnt++;
    end
    ack_i = 1'b0;
    checkOutput("stray ack rsp", 32'(rsp_cnt), 32'h0);
    checkOutput("stray ack cyc", 32'(cyc_cnt), 32'h0);
    checkOutput("stray ack ready", 32'(req_ready), 32'h1);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
